// File: rtl/clk_enable_sched.sv
// rtl/clk_enable_sched.sv - core clock-enable scheduler (free-run divider, single-step, halt)
//
// Generates the single-cycle core clock-enable pulse that advances the cores.
// Everything runs on the board clock; no derived clocks are produced.
//
// Ports:
//   Clk      in   board clock
//   Rst      in   asynchronous active-high reset
//   Mode     in   00/11 halt, 01 run, 10 step
//   StepReq  in   step push-button level, asynchronous to Clk
//   DivLoad  in   load DivVal into the divisor register (clears divide counter)
//   DivVal   in   new divisor; pulse period in RUN is DivVal+1 cycles
//   CntClr   in   synchronous clear of PulseCnt, wins over increment
//   CoreEn   out  registered one-cycle core enable
//   Running  out  registered, high while in RUN
//   PulseCnt out  count of emitted CoreEn pulses, wraps
module clk_enable_sched #(
    parameter int DIV_W   = 26,
    parameter int DEF_DIV = 1250000,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [1:0]       Mode,
    input  logic             StepReq,
    input  logic             DivLoad,
    input  logic [DIV_W-1:0] DivVal,
    input  logic             CntClr,
    output logic             CoreEn,
    output logic             Running,
    output logic [CNT_W-1:0] PulseCnt
);

    localparam logic [DIV_W-1:0] L_DEF_DIV = DIV_W'(DEF_DIV);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic               r_s1;
    logic               r_s2;
    logic               r_s3;
    logic               r_core_en;
    logic               w_core_en;
    logic               r_running;
    logic [CNT_W-1:0]   r_pulse_cnt;
    logic               w_stay_run;
    logic               w_stay_step;
    logic               w_hit;
    logic               w_rise;

    // The next state depends only on Mode, so every legal transition
    // (including RUN <-> STEP) falls out of this decode.
    always_comb begin
        w_next = S_HALT;
        case (Mode)
            2'b01:   w_next = S_RUN;
            2'b10:   w_next = S_STEP;
            default: w_next = S_HALT;
        endcase
    end

    // Work is done only on edges where the FSM stays in its state: the
    // entering edge clears the count, and a leaving edge discards any pulse.
    assign w_stay_run  = (r_state == S_RUN)  && (w_next == S_RUN);
    assign w_stay_step = (r_state == S_STEP) && (w_next == S_STEP);
    assign w_hit       = (r_cnt == r_div);
    assign w_rise      = r_s2 & ~r_s3;

    always_comb begin
        w_core_en = 1'b0;
        w_cnt_nxt = '0;
        if (!DivLoad && w_stay_run) begin
            if (w_hit) begin
                w_core_en = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + DIV_W'(1);
            end
        end
        // A divisor load restarts the period, so it suppresses a pending hit.
        if (w_stay_step && w_rise) begin
            w_core_en = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= S_HALT;
            r_div       <= L_DEF_DIV;
            r_cnt       <= '0;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_core_en   <= 1'b0;
            r_running   <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_s1      <= StepReq;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_cnt     <= w_cnt_nxt;
            r_core_en <= w_core_en;
            r_running <= (w_next == S_RUN);
            if (DivLoad) begin
                r_div <= DivVal;
            end
            if (CntClr) begin
                r_pulse_cnt <= '0;
            end else if (r_core_en) begin
                r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
            end
        end
    end

    assign CoreEn   = r_core_en;
    assign Running  = r_running;
    assign PulseCnt = r_pulse_cnt;

endmodule

// File: tb/tb_clk_enable_sched.sv
// tb/tb_clk_enable_sched.sv - self-checking bench for clk_enable_sched
module tb_clk_enable_sched;

    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 9;
    localparam int CNT_W   = 4;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [1:0]       Mode = 2'b00;
    logic             StepReq = 1'b0;
    logic             DivLoad = 1'b0;
    logic [DIV_W-1:0] DivVal = '0;
    logic             CntClr = 1'b0;
    logic             CoreEn;
    logic             Running;
    logic [CNT_W-1:0] PulseCnt;

    int n_checks = 0;
    int n_errors = 0;

    clk_enable_sched #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .Mode(Mode), .StepReq(StepReq), .DivLoad(DivLoad),
        .DivVal(DivVal), .CntClr(CntClr), .CoreEn(CoreEn), .Running(Running),
        .PulseCnt(PulseCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 halt, 1 run, 2 step. Run pulses are found by
    // counting edges since the period restarted; step pulses from the history
    // of sampled button levels (newest first).
    int m_state, m_el, m_div, m_pc;
    bit m_en, m_run;
    bit smp[$];

    function automatic int mode_of(input logic [1:0] m);
        return (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : 0;
    endfunction

    always @(posedge Clk or posedge Rst) begin
        int nxt;
        bit rise, en;
        if (Rst) begin
            m_state = 0; m_el = 0; m_div = DEF_DIV; m_en = 0; m_run = 0; m_pc = 0;
            smp = '{1'b0, 1'b0, 1'b0};
        end else begin
            nxt  = mode_of(Mode);
            // A press sampled at edge k is seen as a rise at edge k+2.
            rise = smp[1] && !smp[2];
            m_pc = CntClr ? 0 : (m_pc + (m_en ? 1 : 0)) % (1 << CNT_W);
            en   = 0;
            if (DivLoad) begin
                m_div = int'(DivVal);
                m_el  = 0;
            end else if (m_state == 1 && nxt == 1) begin
                m_el++;
                if (m_el == m_div + 1) begin
                    en   = 1;
                    m_el = 0;
                end
            end else begin
                m_el = 0;
            end
            if (m_state == 2 && nxt == 2 && rise) en = 1;
            smp.push_front(StepReq);
            void'(smp.pop_back());
            m_en    = en;
            m_run   = (nxt == 1);
            m_state = nxt;
        end
    end

    always @(negedge Clk) begin
        chk("model_CoreEn", int'(CoreEn), int'(m_en));
        chk("model_Running", int'(Running), int'(m_run));
        chk("model_PulseCnt", int'(PulseCnt), m_pc);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Edges stepped until CoreEn is seen high (bounded).
    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!CoreEn && n < 200);
    endtask

    task automatic count_pulses(input int edges, output int cnt);
        cnt = 0;
        for (int i = 0; i < edges; i++) begin
            step();
            if (CoreEn) cnt++;
        end
    endtask

    initial begin
        int n, cnt, bad;

        // Reset defaults
        step(); step();
        chk("rst_CoreEn", int'(CoreEn), 0);
        chk("rst_Running", int'(Running), 0);
        chk("rst_PulseCnt", int'(PulseCnt), 0);
        Rst = 1'b0;
        step();
        Mode = 2'b01;
        wait_pulse(n);
        chk("first_pulse_edges", n, DEF_DIV + 2);
        wait_pulse(n);
        chk("def_period", n, DEF_DIV + 1);
        chk("mid_pulse_PulseCnt", int'(PulseCnt), 1);
        // Reset mid-pulse while running
        Rst = 1'b1;
        #1;
        chk("async_rst_CoreEn", int'(CoreEn), 0);
        chk("async_rst_Running", int'(Running), 0);
        chk("async_rst_PulseCnt", int'(PulseCnt), 0);
        step();
        Rst = 1'b0;
        wait_pulse(n);
        chk("post_rst_first_pulse", n, DEF_DIV + 2);

        // Divide period with DivVal=3
        Mode = 2'b00;
        step();
        CntClr = 1'b1;
        step();
        CntClr = 1'b0;
        DivLoad = 1'b1; DivVal = 8'd3; Mode = 2'b01;
        step();
        DivLoad = 1'b0;
        cnt = 0; bad = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (CoreEn) cnt++;
            if (int'(CoreEn) != ((i % 4 == 0) ? 1 : 0)) bad++;
        end
        chk("div3_pulses", cnt, 5);
        chk("div3_pattern_bad", bad, 0);
        step();
        chk("div3_PulseCnt", int'(PulseCnt), 5);

        // Divisor zero, then reload mid-run
        DivLoad = 1'b1; DivVal = 8'd0;
        step();
        DivLoad = 1'b0;
        count_pulses(5, cnt);
        chk("div0_every_cycle", cnt, 5);
        DivLoad = 1'b1; DivVal = 8'd2;
        step();
        DivLoad = 1'b0;
        chk("reload_edge_no_pulse", int'(CoreEn), 0);
        wait_pulse(n);
        chk("reload_next_pulse", n, 3);

        // Mode changes: leave RUN at Cnt=2 with divisor 5
        DivLoad = 1'b1; DivVal = 8'd5;
        step();
        DivLoad = 1'b0;
        step(); step();
        Mode = 2'b00;
        step();
        chk("halt_Running", int'(Running), 0);
        count_pulses(8, cnt);
        chk("halt_no_pulse", cnt, 0);
        Mode = 2'b01;
        wait_pulse(n);
        chk("reentry_pulse", n, 7);
        StepReq = 1'b1;
        count_pulses(12, cnt);
        chk("run_ignores_step", cnt, 2);
        StepReq = 1'b0;
        step(); step(); step(); step();

        // Step mode: hold 50 cycles, release, press again
        Mode = 2'b10; CntClr = 1'b1;
        step();
        CntClr = 1'b0;
        StepReq = 1'b1;
        wait_pulse(n);
        chk("step1_latency", n, 3);
        count_pulses(47, cnt);
        chk("step_hold_no_repeat", cnt, 0);
        StepReq = 1'b0;
        count_pulses(5, cnt);
        chk("step_release_no_pulse", cnt, 0);
        StepReq = 1'b1;
        wait_pulse(n);
        chk("step2_latency", n, 3);
        StepReq = 1'b0;
        step(); step();
        chk("step_PulseCnt", int'(PulseCnt), 2);

        // Counter wrap and clear
        Mode = 2'b01; DivLoad = 1'b1; DivVal = 8'd0; CntClr = 1'b1;
        step();
        DivLoad = 1'b0; CntClr = 1'b0;
        repeat (16) step();
        chk("wrap_pre", int'(PulseCnt), 15);
        step();
        chk("wrap_zero", int'(PulseCnt), 0);
        step();
        chk("wrap_one", int'(PulseCnt), 1);
        chk("wrap_CoreEn_high", int'(CoreEn), 1);
        CntClr = 1'b1;
        step();
        chk("clr_beats_inc", int'(PulseCnt), 0);
        CntClr = 1'b0;
        Mode = 2'b00;
        step(); step(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
